iq_symbol_mapper: RTL
=====================

Name: iq_symbol_mapper

Overview:
- Upstream feeder for the IQ modulator.
- Accepts payload bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte MSB-first into QPSK (2-bit) or 16-QAM (4-bit) symbols and maps each symbol to signed 8-bit I/Q.
- Holds each I/Q pair for SYMLEN clocks. Outputs are posedge-registered, so they are stable when the modulator samples them on negedge.

Parameters:
- SYMLEN, 32: clocks per symbol; legal range 2..65535.
- FIFO_DEPTH, 4: byte FIFO depth; power of two, at least 2.
- AMP, 90: outer amplitude, at most 127. Inner 16-QAM level is AMP/3 (integer divide), which is 30 at the default.

Ports:
- clk, in, 1: system clock, posedge.
- reset_, in, 1: asynchronous active-low reset.
- data_in, in, 8: payload byte.
- data_valid, in, 1: data_in is valid.
- data_ready, out, 1: FIFO can accept a byte.
- mode, in, 1: 0 = QPSK, 1 = 16-QAM.
- i, out, 8 signed: in-phase value to the modulator.
- q, out, 8 signed: quadrature value to the modulator.
- sym_strobe, out, 1: high for the first clock of each new symbol.
- busy, out, 1: high while in SEND.
- burst_end, out, 1: one-clock pulse when SEND ends because the FIFO is empty.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFO emptied; count = 0; state = IDLE; shifter cleared.
  - i = q = 0; sym_strobe = busy = burst_end = 0; data_ready = 1.
- FIFO:
  - Write when data_valid && data_ready at a posedge.
  - data_ready = !full, derived from the registered count only.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pop occurs only on symbol-boundary loads (see SEND).
  - Pointers wrap modulo FIFO_DEPTH.
  - Attempted write while full is ignored; ready is already low.
- State machine, IDLE:
  - i = q = 0.
  - If the FIFO is non-empty at a posedge: pop a byte, latch mode into the byte's mode register, output the first symbol, set sym_strobe = 1, clear the symbol counter, go to SEND.
  - Latency: a byte accepted into an empty FIFO at edge N appears on i/q at edge N+1.
- State machine, SEND:
  - Counter increments each clock.
  - At count == SYMLEN-1, the next edge:
    - bits remain in shifter: shift 2 (QPSK) or 4 (16-QAM) bits, output the next symbol, sym_strobe = 1, counter = 0;
    - shifter exhausted and FIFO non-empty: pop, latch mode, output the new byte's first symbol seamlessly with no gap;
    - shifter exhausted and FIFO empty: go to IDLE, i = q = 0, burst_end = 1 for one clock.
- Mode handling:
  - Sampled only when a byte is loaded.
  - A change mid-byte takes effect at the next byte.
  - A byte produces 4 symbols in QPSK and 2 symbols in 16-QAM.
- QPSK mapping, pair b1 b0:
  - b1 gives I, b0 gives Q.
  - bit 0 -> +AMP; bit 1 -> -AMP.
- 16-QAM mapping, nibble b3 b2 b1 b0:
  - b3 b2 gives I; b1 b0 gives Q.
  - Gray code: 00 -> +AMP, 01 -> +AMP/3, 11 -> -AMP/3, 10 -> -AMP.
- Arithmetic:
  - Levels are computed as 8-bit two's complement constants.
  - No saturation is needed because AMP <= 127.
- Reset mid-symbol: all state is discarded immediately; no burst_end pulse.
- data_valid is not required to stay high; no data is lost while data_ready is high.

Test Plan:
- QPSK, one byte 0xB4 (mode=0), SYMLEN=4:
  - i/q sequence (-90,+90), (-90,-90), (+90,-90), (+90,+90), each held 4 clocks.
  - sym_strobe on clocks 0, 4, 8, 12.
  - burst_end one clock after the last hold; then i = q = 0.
- 16-QAM, byte 0xB4 (mode=1):
  - symbols (-90,-30) then (+30,+90).
  - busy high for 2*SYMLEN clocks.
- Back-to-back 0x00, 0xFF in QPSK:
  - 4 symbols of (+90,+90), then 4 symbols of (-90,-90).
  - No idle gap and no burst_end between the bytes.
- Fill FIFO with 5 writes while sending (FIFO_DEPTH=4):
  - data_ready drops after the 4th stored byte.
  - 5th byte is accepted only after the next pop.
  - All bytes are transmitted in order.
- Mode toggled from 0 to 1 mid-byte 0x1B:
  - 0x1B stays QPSK: (+90,+90), (+90,-90), (-90,+90), (-90,-90).
  - Next byte 0x1B is sent as 16-QAM: (+90,+30), (-90,-30).
- Assert reset_ low mid-symbol:
  - i = q = 0 and data_ready = 1 without waiting for a clock edge.
  - After release, previously queued bytes are gone and there is no burst_end pulse.

Source files
------------

// File: rtl/iq_symbol_mapper.sv
// ---------------------------------------------------------------------------
// iq_symbol_mapper
//
// Upstream feeder for the IQ modulator. Payload bytes are buffered in a small
// FIFO, serialized MSB-first into QPSK (2-bit) or 16-QAM (4-bit) symbols, and
// each symbol is mapped to a signed 8-bit I/Q pair. The pair is held for SYMLEN
// clocks. All outputs are posedge-registered, so they are stable when the
// modulator samples on negedge.
//
// Handshake: a byte transfers on any posedge where data_valid && data_ready.
// data_ready is derived only from the registered FIFO count (never from
// data_valid), so the producer may drop data_valid at any time. Nothing is lost
// while data_ready is high.
//
// Ports:
//   clk         in   system clock, posedge
//   reset_      in   asynchronous active-low reset
//   data_in     in   [7:0] payload byte
//   data_valid  in   data_in is valid
//   data_ready  out  FIFO can accept a byte
//   mode        in   0 = QPSK, 1 = 16-QAM (sampled when a byte is loaded)
//   i, q        out  signed [7:0] I/Q value to the modulator
//   sym_strobe  out  high on the first clock of each new symbol
//   busy        out  high while in SEND
//   burst_end   out  one-clock pulse when SEND ends on an empty FIFO
// ---------------------------------------------------------------------------
module iq_symbol_mapper #(
  parameter int SYMLEN     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AMP        = 90
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              mode,
  output logic signed [7:0] i,
  output logic signed [7:0] q,
  output logic              sym_strobe,
  output logic              busy,
  output logic              burst_end
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Constellation levels as 8-bit two's complement constants.
  localparam logic signed [7:0] P_OUT = 8'(AMP);
  localparam logic signed [7:0] P_IN  = 8'(AMP / 3);
  localparam logic signed [7:0] N_IN  = 8'(-(AMP / 3));
  localparam logic signed [7:0] N_OUT = 8'(-AMP);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [15:0]    sym_cnt;
  logic [7:0]     shifter;    // current byte, current symbol in the top bits
  logic           byte_mode;  // mode latched when the current byte was loaded
  logic [1:0]     sym_left;   // symbols of the current byte still to send

  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           at_boundary;
  logic [7:0]     head;
  logic [7:0]     next_shift;

  // Gray-coded 16-QAM level for one axis.
  function automatic logic signed [7:0] qam_level(input logic [1:0] b);
    case (b)
      2'b00:   return P_OUT;
      2'b01:   return P_IN;
      2'b11:   return N_IN;
      default: return N_OUT;
    endcase
  endfunction

  // {I, Q} for the symbol held in the top bits of s.
  function automatic logic [15:0] sym_iq(input logic [7:0] s, input logic m);
    if (!m)
      return {(s[7] ? N_OUT : P_OUT), (s[6] ? N_OUT : P_OUT)};
    else
      return {qam_level(s[7:6]), qam_level(s[5:4])};
  endfunction

  assign fifo_empty  = (count == '0);
  assign data_ready  = (count != CW'(FIFO_DEPTH));
  assign push        = data_valid && data_ready;
  assign at_boundary = (sym_cnt == 16'(SYMLEN - 1));
  assign head        = mem[rd_ptr];
  assign next_shift  = byte_mode ? {shifter[3:0], 4'b0} : {shifter[5:0], 2'b0};

  // A byte is popped only when a new byte must be loaded: from IDLE, or at a
  // symbol boundary once the current byte's symbols are exhausted.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (at_boundary && (sym_left == 2'd0)));

  // Storage carries no reset; emptiness is defined by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sym_cnt    <= '0;
      shifter    <= '0;
      byte_mode  <= 1'b0;
      sym_left   <= '0;
      i          <= '0;
      q          <= '0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
      burst_end  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      sym_strobe <= 1'b0;
      burst_end  <= 1'b0;

      case (state)
        IDLE: begin
          i    <= '0;
          q    <= '0;
          busy <= 1'b0;
          if (pop) begin
            shifter    <= head;
            byte_mode  <= mode;
            {i, q}     <= sym_iq(head, mode);
            sym_left   <= mode ? 2'd1 : 2'd3;
            sym_cnt    <= '0;
            sym_strobe <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end

        SEND: begin
          if (!at_boundary) begin
            sym_cnt <= sym_cnt + 16'd1;
          end else if (sym_left != 2'd0) begin
            shifter    <= next_shift;
            {i, q}     <= sym_iq(next_shift, byte_mode);
            sym_left   <= sym_left - 2'd1;
            sym_cnt    <= '0;
            sym_strobe <= 1'b1;
          end else if (pop) begin
            // Seamless hand-over to the next queued byte.
            shifter    <= head;
            byte_mode  <= mode;
            {i, q}     <= sym_iq(head, mode);
            sym_left   <= mode ? 2'd1 : 2'd3;
            sym_cnt    <= '0;
            sym_strobe <= 1'b1;
          end else begin
            i         <= '0;
            q         <= '0;
            busy      <= 1'b0;
            burst_end <= 1'b1;
            sym_cnt   <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
